// File: rtl/motor_math_pkg.sv
// Fixed-point constants and helpers shared by the forward and inverse Clarke blocks.
package motor_math_pkg;

  localparam int unsigned SCALE   = 12;
  localparam int unsigned K_WIDTH = 14;

  // Coefficients in Q(SCALE) fixed point.
  localparam logic signed [K_WIDTH-1:0] K_U = K_WIDTH'(3344);  // sqrt(2/3)
  localparam logic signed [K_WIDTH-1:0] K_N = K_WIDTH'(1672);  // 1/sqrt(6)
  localparam logic signed [K_WIDTH-1:0] K_B = K_WIDTH'(2896);  // 1/sqrt(2)

  // One-hot multiply sequencer; each state names the work done at its leaving edge.
  typedef enum logic [4:0] {
    SeqIdle  = 5'b00000,
    SeqLoadU = 5'b00001,
    SeqLoadN = 5'b00010,
    SeqLoadB = 5'b00100,
    SeqTakeN = 5'b01000,
    SeqEmit  = 5'b10000
  } inv_clarke_seq_e;

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                     input int unsigned       width);
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val = -max_val - 64'sd1;
    if (value > max_val) return max_val;
    if (value < min_val) return min_val;
    return value;
  endfunction

endpackage

// File: rtl/fixed_scale_sat.sv
// Rescales a Q(SCALE) product (round half up when INV_CLARKE_ROUND_EN is defined, else floor),
// then forms offset +/- the scaled term, each saturated to OUT_WIDTH.
module fixed_scale_sat
  import motor_math_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 30,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]      prod,
  input  logic signed [IN_WIDTH-SCALE+1:0] offset,
  output logic signed [IN_WIDTH-SCALE:0]   shifted,
  output logic signed [OUT_WIDTH-1:0]      sum_sat,
  output logic signed [OUT_WIDTH-1:0]      diff_sat
);

  localparam int unsigned EXT_WIDTH = IN_WIDTH + 1;
  localparam int unsigned SH_WIDTH  = EXT_WIDTH - SCALE;
  localparam int unsigned SUM_WIDTH = SH_WIDTH + 2;

  logic signed [EXT_WIDTH-1:0] prod_ext;
  logic signed [EXT_WIDTH-1:0] prod_rnd;
  logic signed [SUM_WIDTH-1:0] sum;
  logic signed [SUM_WIDTH-1:0] diff;

  // One spare bit so the rounding bias can never wrap the product.
  assign prod_ext = EXT_WIDTH'(prod);

`ifdef INV_CLARKE_ROUND_EN
  localparam logic signed [EXT_WIDTH-1:0] ROUND_BIAS = EXT_WIDTH'(1) <<< (SCALE - 1);
  assign prod_rnd = prod_ext + ROUND_BIAS;
`else
  assign prod_rnd = prod_ext;
`endif

  assign shifted = SH_WIDTH'(prod_rnd >>> SCALE);

  assign sum  = SUM_WIDTH'(offset) + SUM_WIDTH'(shifted);
  assign diff = SUM_WIDTH'(offset) - SUM_WIDTH'(shifted);

  assign sum_sat  = OUT_WIDTH'(sat_to_width(64'(sum), OUT_WIDTH));
  assign diff_sat = OUT_WIDTH'(sat_to_width(64'(diff), OUT_WIDTH));

endmodule

// File: rtl/inverse_clarke_transform.sv
// Power-invariant inverse Clarke {a, b} -> {u, v, w} over Avalon-ST with one shared multiplier.
// Define INV_CLARKE_ROUND_EN for round-half-up rescaling instead of floor.
module inverse_clarke_transform
  import motor_math_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 1,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  input  logic [CHANNEL_WIDTH-1:0]  in_channel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [3*DATA_WIDTH-1:0]   out_data,
  output logic [CHANNEL_WIDTH-1:0]  out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned PROD_WIDTH = DATA_WIDTH + K_WIDTH;
  localparam int unsigned SH_WIDTH   = PROD_WIDTH + 1 - SCALE;

  inv_clarke_seq_e state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            accept;

  logic signed [DATA_WIDTH-1:0] a_q, b_q, u_q, mult_x_q;
  logic signed [K_WIDTH-1:0]    mult_k_q;
  logic signed [PROD_WIDTH-1:0] prod_q;
  logic signed [SH_WIDTH-1:0]   n_q, prod_shifted;
  logic signed [SH_WIDTH:0]     offset;
  logic signed [DATA_WIDTH-1:0] sum_sat, diff_sat;
  logic [CHANNEL_WIDTH-1:0]     ch_q, out_channel_q;
  logic [3*DATA_WIDTH-1:0]      out_data_q;

  assign accept      = in_valid & in_ready_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      SeqIdle: begin
        if (accept) begin
          state_d    = SeqLoadU;
          in_ready_d = 1'b0;
        end else if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SeqLoadU: state_d = SeqLoadN;
      SeqLoadN: state_d = SeqLoadB;
      SeqLoadB: state_d = SeqTakeN;
      SeqTakeN: state_d = SeqEmit;
      SeqEmit: begin
        state_d     = SeqIdle;
        out_valid_d = 1'b1;
      end
      default: state_d = SeqIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SeqIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The shared rescaler yields u (offset 0) at SeqLoadB and v/w (offset -n) at SeqEmit.
  assign offset = (state_q == SeqEmit) ? -((SH_WIDTH + 1)'(n_q)) : '0;

  fixed_scale_sat #(
    .IN_WIDTH  (PROD_WIDTH),
    .OUT_WIDTH (DATA_WIDTH)
  ) u_scale (
    .prod     (prod_q),
    .offset   (offset),
    .shifted  (prod_shifted),
    .sum_sat  (sum_sat),
    .diff_sat (diff_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q           <= '0;
      b_q           <= '0;
      ch_q          <= '0;
      mult_x_q      <= '0;
      mult_k_q      <= '0;
      prod_q        <= '0;
      u_q           <= '0;
      n_q           <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else begin
      prod_q <= PROD_WIDTH'(mult_x_q) * PROD_WIDTH'(mult_k_q);
      if (accept) begin
        a_q  <= in_data[2*DATA_WIDTH-1:DATA_WIDTH];
        b_q  <= in_data[DATA_WIDTH-1:0];
        ch_q <= in_channel;
      end
      unique case (state_q)
        SeqIdle: ;
        SeqLoadU: begin
          mult_x_q <= a_q;
          mult_k_q <= K_U;
        end
        SeqLoadN: begin
          mult_x_q <= a_q;
          mult_k_q <= K_N;
        end
        SeqLoadB: begin
          mult_x_q <= b_q;
          mult_k_q <= K_B;
          u_q      <= sum_sat;
        end
        SeqTakeN: n_q <= prod_shifted;
        SeqEmit: begin
          out_data_q    <= {u_q, sum_sat, diff_sat};
          out_channel_q <= ch_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_clarke_transform.sv
// Scoreboard bench for inverse_clarke_transform (DATA_WIDTH=16, CHANNEL_WIDTH=2).
// Honours INV_CLARKE_ROUND_EN for the rounding-dependent expectations.
module tb_inverse_clarke_transform;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_channel;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic [1:0]  out_channel;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [47:0] data;
    logic [1:0]  ch;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   accept_cyc = 0;

  logic signed [15:0] bnd_a[4] = '{16'sd32767, 16'sd32767, -16'sd32768, -16'sd1};
  logic signed [15:0] bnd_b[4] = '{16'sd32767, -16'sd32768, 16'sd32767, 16'sd1};

  inverse_clarke_transform #(
    .CHANNEL_WIDTH (2),
    .DATA_WIDTH    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_channel  (in_channel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input longint x);
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  function automatic logic [47:0] model(input logic signed [15:0] a, input logic signed [15:0] b);
    longint pu, pn, pb, u, n, t;
    pu = longint'(a) * 3344;
    pn = longint'(a) * 1672;
    pb = longint'(b) * 2896;
`ifdef INV_CLARKE_ROUND_EN
    pu = pu + 2048;
    pn = pn + 2048;
    pb = pb + 2048;
`endif
    u = pu >>> 12;
    n = pn >>> 12;
    t = pb >>> 12;
    return {sat16(u), sat16(-n + t), sat16(-n - t)};
  endfunction

  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic [1:0] ch);
    int   budget = 40;
    exp_t e;
    in_data    = {a, b};
    in_channel = ch;
    in_valid   = 1'b1;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("accept_ready", in_ready, 1);
    e.data = model(a, b);
    e.ch   = ch;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] eu, input logic [15:0] ev,
                               input logic [15:0] ew, input logic [1:0] ech, input bit chk_lat);
    int budget = 30;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq({tag, "_valid"}, out_valid, 1);
    if (chk_lat) check_eq({tag, "_latency"}, cyc - accept_cyc, 5);
    check_eq({tag, "_u"}, out_data[47:32], eu);
    check_eq({tag, "_v"}, out_data[31:16], ev);
    check_eq({tag, "_w"}, out_data[15:0], ew);
    check_eq({tag, "_ch"}, out_channel, ech);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int budget = 40;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq(tag, sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Pop on each output handshake, sampled half a cycle before the consuming edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", out_valid, 0);
      end else begin
        mon_exp = sb_q.pop_front();
        check_eq("sb_data", out_data, mon_exp.data);
        check_eq("sb_ch", out_channel, mon_exp.ch);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    logic [47:0] snap;
    int          n_before;
    int          budget;
    logic signed [15:0] ra, rb;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_channel = '0;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_channel", out_channel, 0);
    #1 reset = 1'b0;
    check_eq("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    check_eq("rel_in_ready_high", in_ready, 1);

    // Basic vectors with fixed expectations.
    send(16'sd4096, 16'sd0, 2'd1);
    expect_result("t1", 16'd3344, -16'sd1672, -16'sd1672, 2'd1, 1'b1);
    send(16'sd0, 16'sd4096, 2'd2);
    expect_result("t2a", 16'd0, 16'd2896, -16'sd2896, 2'd2, 1'b1);
    send(16'sd0, -16'sd4096, 2'd3);
    expect_result("t2b", 16'd0, -16'sd2896, 16'd2896, 2'd3, 1'b0);
    send(-16'sd32768, -16'sd32768, 2'd0);
    expect_result("t3", -16'sd26752, -16'sd9792, 16'sd32767, 2'd0, 1'b0);
    send(16'sd1, 16'sd0, 2'd1);
`ifdef INV_CLARKE_ROUND_EN
    expect_result("t6", 16'd1, 16'd0, 16'd0, 2'd1, 1'b0);
`else
    expect_result("t6", 16'd0, 16'd0, 16'd0, 2'd1, 1'b0);
`endif

    // Backpressure with a second beat waiting.
    out_ready = 1'b0;
    send(16'sd1000, -16'sd2000, 2'd2);
    in_data    = {16'sd300, 16'sd500};
    in_channel = 2'd1;
    in_valid   = 1'b1;
    budget     = 30;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("bp_valid", out_valid, 1);
    snap     = out_data;
    n_before = n_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_stable", out_data, snap);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_before", in_ready, 0);
    @(negedge clk);
    check_eq("bp_ready_after", in_ready, 1);
    check_eq("bp_consumed", out_valid, 0);
    check_eq("bp_one_delivery", n_out - n_before, 1);
    check_eq("bp_data_held", out_data, snap);
    send(16'sd300, 16'sd500, 2'd1);
    wait_drain("bp_second");

    // Reset two edges after an accept.
    send(16'sd2000, 16'sd1000, 2'd3);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_data", out_data, 0);
    check_eq("mid_rst_out_channel", out_channel, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_valid", out_valid, 0);
      check_eq("post_rst_data", out_data, 0);
    end
    send(16'sd4096, 16'sd0, 2'd2);
    expect_result("t5", 16'd3344, -16'sd1672, -16'sd1672, 2'd2, 1'b1);

    // Boundary and random operands against the model.
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        ra = bnd_a[i];
        rb = bnd_b[i];
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      send(ra, rb, 2'($urandom_range(0, 3)));
      wait_drain("rand");
    end

    check_eq("sb_final_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
